// File: rtl/segasys1_sprrom_arb.sv
// Two-port arbiter for the sprite chip-ROM: fixed priority to A with starvation relief for B, bounded ROM wait.
// Optional one-entry read cache enabled by defining SPRROM_ARB_CACHE_EN.
module segasys1_sprrom_arb #(
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 4
) (
    input  logic        VCLKx4,
    input  logic        RESET,
    input  logic        a_req,
    input  logic [17:0] a_addr,
    output logic        a_ack,
    input  logic        b_req,
    input  logic [17:0] b_addr,
    output logic        b_ack,
    output logic [7:0]  rd_data,
    output logic        rom_rd,
    output logic [17:0] rom_addr,
    input  logic        rom_valid,
    input  logic [7:0]  rom_data,
    output logic        err
);

    localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t      state_q;
    logic [17:0] addr_q;
    logic        sel_b_q;
    logic [2:0]  starve_q;
    logic [7:0]  wait_q;
    logic [7:0]  data_q;
    logic        rom_rd_q;
    logic        a_ack_q;
    logic        b_ack_q;
    logic        err_q;

    logic        pick_b_d;
    logic [17:0] win_addr_d;
    logic        grant_d;
    logic [7:0]  wait_d;
    logic        fill_d;
    logic        tmo_d;
    logic        hit_d;

    assign pick_b_d   = b_req && (!a_req || (starve_q == STARVE_LIM));
    assign win_addr_d = pick_b_d ? b_addr : a_addr;
    // The ack cycle still sees the old req, so no grant is made until the cycle after it.
    assign grant_d    = (state_q == IDLE) && (a_req || b_req) && !a_ack_q && !b_ack_q;
    assign wait_d     = wait_q + 8'd1;
    assign fill_d     = (state_q == WAIT) && rom_valid;
    assign tmo_d      = (state_q == WAIT) && !rom_valid && (wait_d == TMO_LIM);

`ifdef SPRROM_ARB_CACHE_EN
    logic [17:0] tag_addr_q;
    logic [7:0]  tag_data_q;
    logic        tag_vld_q;

    assign hit_d = tag_vld_q && (tag_addr_q == win_addr_d);

    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            tag_vld_q <= 1'b0;
        end else if (fill_d) begin
            tag_vld_q  <= 1'b1;
            tag_addr_q <= addr_q;
            tag_data_q <= rom_data;
        end else if (tmo_d) begin
            tag_vld_q <= 1'b0;
        end
    end
`else
    assign hit_d = 1'b0;
`endif

    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            state_q  <= IDLE;
            rom_rd_q <= 1'b0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= 8'h00;
            starve_q <= 3'd0;
            wait_q   <= 8'd0;
        end else begin
            rom_rd_q <= 1'b0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;

            // Starvation count only tracks A grants made while B is actually waiting.
            if (!b_req) begin
                starve_q <= 3'd0;
            end else if (grant_d) begin
                if (pick_b_d) begin
                    starve_q <= 3'd0;
                end else if (starve_q != 3'd7) begin
                    starve_q <= starve_q + 3'd1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        sel_b_q <= pick_b_d;
                        addr_q  <= win_addr_d;
                        if (hit_d) begin
`ifdef SPRROM_ARB_CACHE_EN
                            data_q <= tag_data_q;
`endif
                            state_q <= DONE;
                        end else begin
                            rom_rd_q <= 1'b1;
                            state_q  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wait_q  <= 8'd0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A response landing on the timeout cycle still wins.
                    if (rom_valid) begin
                        data_q  <= rom_data;
                        state_q <= DONE;
                    end else if (tmo_d) begin
                        data_q  <= 8'hFF;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                DONE: begin
                    a_ack_q <= !sel_b_q;
                    b_ack_q <= sel_b_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign rd_data  = data_q;
    assign rom_rd   = rom_rd_q;
    assign rom_addr = addr_q;
    assign err      = err_q;

endmodule

// File: tb/tb_segasys1_sprrom_arb.sv
// Scoreboard bench for segasys1_sprrom_arb: stimulus pushes predicted acks, a monitor pops them, a ROM model answers reads.
module tb_segasys1_sprrom_arb;

    localparam int TIMEOUT    = 15;
    localparam int STARVE_MAX = 4;
`ifdef SPRROM_ARB_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        RESET;
    logic        a_req, b_req;
    logic [17:0] a_addr, b_addr;
    logic        a_ack, b_ack;
    logic [7:0]  rd_data;
    logic        rom_rd;
    logic [17:0] rom_addr;
    logic        rom_valid;
    logic [7:0]  rom_data;
    logic        err;

    segasys1_sprrom_arb #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
        .VCLKx4(clk), .RESET(RESET),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack),
        .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack),
        .rd_data(rd_data),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_valid(rom_valid), .rom_data(rom_data),
        .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         port_b;
        logic [7:0] data;
        bit         err;
        int         t0;
        int         lat;
    } exp_t;

    exp_t        sbq[$];
    logic [17:0] romq[$];

    bit          m_tag_v = 1'b0;
    logic [17:0] m_tag_a = '0;
    logic [7:0]  m_tag_d = '0;
    bit          m_err   = 1'b0;
    int          rsp_delay = 1;
    bit          no_hold_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rom_byte(input logic [17:0] a);
        if (a == 18'h01234) return 8'h5A;
        if (a == 18'h00777) return 8'h3C;
        return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'h96;
    endfunction

    // Outcome of one fetch from the rules: cache hit, ROM reply within the limit, or timeout.
    function automatic void predict(input bit pb, input logic [17:0] addr, input int d,
                                    input int t0, input bit chk_lat);
        exp_t e;
        e.port_b = pb;
        e.t0     = t0;
        if (CACHE && m_tag_v && (m_tag_a == addr)) begin
            e.data = m_tag_d;
            e.lat  = 2;
        end else begin
            romq.push_back(addr);
            if (d <= TIMEOUT) begin
                e.data  = rom_byte(addr);
                e.lat   = 3 + d;
                m_tag_v = 1'b1;
                m_tag_a = addr;
                m_tag_d = e.data;
            end else begin
                e.data  = 8'hFF;
                e.lat   = 3 + TIMEOUT;
                m_err   = 1'b1;
                m_tag_v = 1'b0;
            end
        end
        if (!chk_lat) e.lat = -1;
        e.err = m_err;
        sbq.push_back(e);
    endfunction

    task automatic check_reset_vals();
        check("reset_rom_rd", 32'(rom_rd), 32'd0);
        check("reset_a_ack", 32'(a_ack), 32'd0);
        check("reset_b_ack", 32'(b_ack), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'h00);
    endtask

    task automatic do_txn(input bit pb, input logic [17:0] addr, input int d);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        rsp_delay = d;
        predict(pb, addr, d, cyc, 1'b1);
        if (pb) begin b_req = 1'b1; b_addr = addr; end
        else begin a_req = 1'b1; a_addr = addr; end
        for (int i = 0; i < 64 && !got; i++) begin
            @(posedge clk); #1;
            if (pb ? b_ack : a_ack) got = 1'b1;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check("ack_arrived", 32'(got), 32'd1);
        repeat (6) @(posedge clk);
    endtask

    // ROM model: answers each read after rsp_delay cycles, possibly too late.
    initial begin
        logic [17:0] ea;
        int d;
        forever begin
            @(posedge clk); #1;
            if (rom_rd) begin
                d = rsp_delay;
                if (romq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rom_rd: got addr %0h expected no read", rom_addr);
                    ea = rom_addr;
                end else begin
                    ea = romq.pop_front();
                    check("rom_addr", 32'(rom_addr), 32'(ea));
                end
                @(posedge clk); #1;
                check("rom_rd_pulse", 32'(rom_rd), 32'd0);
                for (int k = 1; k < d; k++) begin
                    @(posedge clk); #1;
                end
                if (d <= TIMEOUT && !no_hold_chk) check("rom_addr_hold", 32'(rom_addr), 32'(ea));
                rom_valid = 1'b1;
                rom_data  = rom_byte(ea);
                @(posedge clk); #1;
                rom_valid = 1'b0;
                rom_data  = 8'($urandom);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (a_ack || b_ack) begin
                check("ack_exclusive", 32'(a_ack & b_ack), 32'd0);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got a_ack=%0d b_ack=%0d expected none", a_ack, b_ack);
                end else begin
                    e = sbq.pop_front();
                    check("ack_port", 32'(b_ack), 32'(e.port_b));
                    check("rd_data", 32'(rd_data), 32'(e.data));
                    check("err", 32'(err), 32'(e.err));
                    if (e.lat >= 0) check("latency", 32'(cyc - e.t0), 32'(e.lat));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "time limit");
    end

    initial begin
        logic [17:0] pool [4];
        bit got;
        pool[0] = 18'h00100; pool[1] = 18'h3F00F; pool[2] = 18'h12345; pool[3] = 18'h00777;
        RESET = 1'b1; a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;
        rom_valid = 1'b0; rom_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        RESET = 1'b0;
        repeat (2) @(posedge clk);

        do_txn(1'b0, 18'h01234, 2);
        do_txn(1'b0, 18'h01234, 2);
        do_txn(1'b1, 18'h00777, TIMEOUT);
        do_txn(1'b0, 18'h00321, TIMEOUT + 3);
        do_txn(1'b1, 18'h00055, 1);
        do_txn(1'b0, 18'h00056, TIMEOUT + 1);
        do_txn(1'b0, 18'h00057, 1);

        // Both ports requesting: A is served STARVE_MAX times, then B.
        @(posedge clk); #1;
        rsp_delay = 1;
        for (int i = 0; i < STARVE_MAX; i++) predict(1'b0, 18'h0AAA0, 1, 0, 1'b0);
        predict(1'b1, 18'h0BBB0, 1, 0, 1'b0);
        a_req = 1'b1; a_addr = 18'h0AAA0;
        b_req = 1'b1; b_addr = 18'h0BBB0;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk); #1;
            if (b_ack) got = 1'b1;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check("starve_b_ack", 32'(got), 32'd1);
        repeat (6) @(posedge clk);

        for (int n = 0; n < 20; n++) begin
            int idx;
            idx = int'($urandom_range(0, 3));
            do_txn(1'($urandom_range(0, 1)), pool[idx], int'($urandom_range(1, TIMEOUT + 3)));
        end

        // Reset in the middle of a ROM wait abandons the fetch silently.
        @(posedge clk); #1;
        no_hold_chk = 1'b1;
        rsp_delay = 3;
        romq.push_back(18'h2AAAA);
        a_req = 1'b1; a_addr = 18'h2AAAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        RESET = 1'b1;
        a_req = 1'b0;
        @(posedge clk); #1;
        RESET = 1'b0;
        check_reset_vals();
        m_err   = 1'b0;
        m_tag_v = 1'b0;
        repeat (10) @(posedge clk);
        no_hold_chk = 1'b0;
        do_txn(1'b0, 18'h0ABCD, 3);
        do_txn(1'b1, 18'h0ABCD, 2);

        repeat (30) @(posedge clk);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        check("rom_queue_empty", 32'(romq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/segasys1_sprrom_arb.md
SEGASYS1_SPRROM_ARB -- requirements
Module: segasys1_sprrom_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles before a fetch is aborted (range 2..255).
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive port-A grants allowed while port B is pending.
REQ-003 SHALL have port VCLKx4, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports a_req (in, 1), a_addr (in, 18) and a_ack (out, 1): sprite-renderer fetch request, chip-ROM byte address and one-cycle completion pulse.
REQ-006 SHALL have ports b_req (in, 1), b_addr (in, 18) and b_ack (out, 1): secondary requester (ROM test/debug reader), same semantics as port A.
REQ-007 SHALL have port rd_data, out, 8: fetched byte, valid in the cycle a_ack or b_ack is high and held until the next ack.
REQ-008 SHALL have ports rom_rd (out, 1), rom_addr (out, 18), rom_valid (in, 1) and rom_data (in, 8): external chip-ROM read handshake.
REQ-009 SHALL have port err, out, 1: sticky timeout flag, cleared only by RESET.

Function
REQ-010 SHALL implement an FSM with states IDLE, ISSUE, WAIT and DONE.
REQ-011 IDLE: with any request pending, SHALL latch the winner and its address, then go to ISSUE on the next cycle.
REQ-012 Arbitration SHALL be fixed priority to A, except that B wins when the starvation counter equals STARVE_MAX and b_req is high.
REQ-013 Starvation counter (3 bits, saturating) SHALL increment on each A grant made while b_req is high, and clear on any B grant or when b_req is low.
REQ-014 ISSUE: SHALL assert rom_rd for exactly one cycle with rom_addr equal to the latched address, then go to WAIT.
REQ-015 rom_addr SHALL hold the latched address from ISSUE until DONE completes.
REQ-016 WAIT: on rom_valid SHALL capture rom_data into rd_data and go to DONE.
REQ-017 WAIT: when the wait counter reaches TIMEOUT without rom_valid, SHALL set rd_data to 8'hFF, set err and go to DONE.
REQ-018 rom_valid arriving in the same cycle as the timeout SHALL take precedence: data is captured and err is not set.
REQ-019 rom_valid received outside WAIT SHALL be ignored.
REQ-020 DONE: SHALL pulse the granted port's ack for one cycle, then return to IDLE; a new grant can occur on the following cycle.
REQ-021 Requesters SHALL keep req and addr stable until ack; a req that drops before ack does not cancel the fetch in flight (the ack is still pulsed).
REQ-022 Latency from req sampled in IDLE to ack SHALL be 3 + N cycles, where N (>=1) is the number of WAIT cycles.
REQ-023 a_ack and b_ack SHALL never be high in the same cycle.
REQ-024 The wait counter SHALL be 8 bits, cleared on entry to WAIT, with no wrap before TIMEOUT.

Reset
REQ-025 RESET SHALL force state IDLE; rom_rd, a_ack, b_ack and err to 0; rd_data to 8'h00; starvation counter, wait counter and cache-valid to 0.
REQ-026 RESET during WAIT SHALL abandon the fetch with no ack issued; a late rom_valid is then ignored per REQ-019.

Configuration
REQ-027 With macro SPRROM_ARB_CACHE_EN defined, SHALL keep a one-entry tag (last address plus data plus valid bit).
REQ-028 With SPRROM_ARB_CACHE_EN defined, a winning request whose address matches the valid tag SHALL go IDLE->DONE with no rom_rd, an ack two cycles after the request and rd_data equal to the cached byte.
REQ-029 With SPRROM_ARB_CACHE_EN defined, a timeout SHALL invalidate the tag.
REQ-030 Without SPRROM_ARB_CACHE_EN, every grant SHALL issue rom_rd and no tag logic SHALL exist.

Verification
REQ-031 a_req, a_addr=18'h01234; rom_valid 2 cycles after rom_rd with data 8'h5A -> one rom_rd with rom_addr=18'h01234; a_ack once, 5 cycles after the request; rd_data=8'h5A.
REQ-032 a_req held continuously and b_req high -> B granted after exactly 4 A grants; b_ack observed; never both acks in one cycle.
REQ-033 rom_valid never returned, TIMEOUT=15 -> ack 18 cycles after the request, rd_data=8'hFF, err=1 and still 1 after later successful fetches.
REQ-034 rom_valid in the same cycle as the timeout with data 8'h3C -> rd_data=8'h3C, err=0.
REQ-035 RESET pulsed in WAIT, then rom_valid arrives -> no ack, all outputs at reset values, next request served normally.
REQ-036 With SPRROM_ARB_CACHE_EN defined, the same address fetched twice -> second fetch issues no rom_rd, ack 2 cycles after the request, same data.
